// File: rtl/axi_inter_cmd_driver_if.sv
`default_nettype none
// ============================================================================
// axi_inter_cmd_driver_if : command, D-bus and response signals of one driver
// Revision 1.0
// ============================================================================
interface axi_inter_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_action;
  logic [2:0]  cmd_formula;
  logic [7:0]  cmd_dram_no;
  logic [47:0] cmd_index;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_result;
  logic        rsp_timeout;
  logic        spurious_out;
  logic        in_valid;
  logic        action_valid;
  logic        formula_valid;
  logic        dram_no_valid;
  logic        index_valid;
  logic [11:0] D;
  logic        out_valid;
  logic [11:0] result;

  modport master (
    input  cmd_valid, cmd_action, cmd_formula, cmd_dram_no, cmd_index,
           rsp_ready, out_valid, result,
    output cmd_ready, rsp_valid, rsp_result, rsp_timeout, spurious_out,
           in_valid, action_valid, formula_valid, dram_no_valid, index_valid, D
  );

  modport slave (
    output cmd_valid, cmd_action, cmd_formula, cmd_dram_no, cmd_index,
           rsp_ready, out_valid, result,
    input  cmd_ready, rsp_valid, rsp_result, rsp_timeout, spurious_out,
           in_valid, action_valid, formula_valid, dram_no_valid, index_valid, D
  );
endinterface
`default_nettype wire

// File: rtl/axi_inter_cmd_driver.sv
`default_nettype none
// ============================================================================
// axi_inter_cmd_driver : buffers host commands, serialises them onto D, returns result
// Revision 1.0
// ============================================================================
module axi_inter_cmd_driver #(
  parameter int CMD_DEPTH = 2,
  parameter int GAP       = 0,
  parameter int TIMEOUT   = 1024
) (
  input wire logic               clk,
  input wire logic               rst,
  axi_inter_cmd_driver_if.master bus
);
  localparam int                PTR_W     = $clog2(CMD_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam int                WAIT_W    = $clog2(TIMEOUT);
  localparam int                CMD_W     = 60;
  localparam logic [3:0]        GAP_LAST  = 4'(GAP);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CMD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ACT, S_FORM, S_DRAM, S_IDX, S_WAIT, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, push, pop;

  logic               work_action;
  logic [2:0]         work_formula;
  logic [7:0]         work_dram;
  logic [47:0]        work_index;

  logic [3:0]         gap_q, gap_d;
  logic [1:0]         idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic               rsp_valid_q, rsp_timeout_q, spurious_q;
  logic [11:0]        rsp_result_q;

  logic               in_valid_q, action_valid_q, formula_valid_q, dram_valid_q, index_valid_q;
  logic               in_valid_d, action_valid_d, formula_valid_d, dram_valid_d, index_valid_d;
  logic [11:0]        d_q, d_d;
  logic               emit;

  assign push = bus.cmd_valid && ready_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {bus.cmd_action, bus.cmd_formula, bus.cmd_dram_no, bus.cmd_index};
  end

  // Field states hold for GAP extra cycles after emitting; the last index goes straight to WAIT.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !rsp_valid_q) begin
          pop     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_ACT;
        gap_d   = '0;
        idx_d   = '0;
      end
      S_ACT, S_FORM, S_DRAM: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = (state_q == S_ACT)  ? S_FORM :
                    (state_q == S_FORM) ? S_DRAM : S_IDX;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_IDX: begin
        if (idx_q == 2'd3) begin
          state_d = S_WAIT;
          idx_d   = '0;
          wait_d  = '0;
        end else if (gap_q == GAP_LAST) begin
          gap_d = '0;
          idx_d = idx_q + 2'd1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (bus.out_valid || wait_q == WAIT_LAST)
          state_d = S_RESP;
        else
          wait_d = wait_q + WAIT_W'(1);
      end
      S_RESP: begin
        if (bus.rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    emit            = (gap_d == 4'd0);
    action_valid_d  = emit && (state_d == S_ACT);
    in_valid_d      = action_valid_d;
    formula_valid_d = emit && (state_d == S_FORM);
    dram_valid_d    = emit && (state_d == S_DRAM);
    index_valid_d   = emit && (state_d == S_IDX);

    d_d = '0;
    if (action_valid_d)
      d_d = {11'd0, work_action};
    else if (formula_valid_d)
      d_d = {9'd0, work_formula};
    else if (dram_valid_d)
      d_d = {4'd0, work_dram};
    else if (index_valid_d) begin
      case (idx_d)
        2'd0:    d_d = work_index[47:36];
        2'd1:    d_d = work_index[35:24];
        2'd2:    d_d = work_index[23:12];
        default: d_d = work_index[11:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      ready_q         <= 1'b1;
      work_action     <= 1'b0;
      work_formula    <= '0;
      work_dram       <= '0;
      work_index      <= '0;
      gap_q           <= '0;
      idx_q           <= '0;
      wait_q          <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_result_q    <= '0;
      spurious_q      <= 1'b0;
      in_valid_q      <= 1'b0;
      action_valid_q  <= 1'b0;
      formula_valid_q <= 1'b0;
      dram_valid_q    <= 1'b0;
      index_valid_q   <= 1'b0;
      d_q             <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      ready_q <= (count_d != CNT_FULL);
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        {work_action, work_formula, work_dram, work_index} <= mem[rd_ptr];
      end

      // A result on the terminal WAIT cycle wins over the timeout.
      if (state_q == S_WAIT) begin
        if (bus.out_valid) begin
          rsp_valid_q   <= 1'b1;
          rsp_result_q  <= bus.result;
          rsp_timeout_q <= 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          rsp_valid_q   <= 1'b1;
          rsp_result_q  <= '0;
          rsp_timeout_q <= 1'b1;
        end
      end else if (state_q == S_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      if (bus.out_valid && state_q != S_WAIT)
        spurious_q <= 1'b1;

      in_valid_q      <= in_valid_d;
      action_valid_q  <= action_valid_d;
      formula_valid_q <= formula_valid_d;
      dram_valid_q    <= dram_valid_d;
      index_valid_q   <= index_valid_d;
      d_q             <= d_d;
    end
  end

  assign bus.cmd_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_timeout   = rsp_timeout_q;
  assign bus.spurious_out  = spurious_q;
  assign bus.in_valid      = in_valid_q;
  assign bus.action_valid  = action_valid_q;
  assign bus.formula_valid = formula_valid_q;
  assign bus.dram_no_valid = dram_valid_q;
  assign bus.index_valid   = index_valid_q;
  assign bus.D             = d_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_inter_cmd_driver.sv
`default_nettype none
// ============================================================================
// tb_axi_inter_cmd_driver : directed bench, port A (GAP=0,TIMEOUT=16), port B (GAP=2,TIMEOUT=64)
// Revision 1.0
// ============================================================================
module tb_axi_inter_cmd_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_inter_cmd_driver_if ifa ();
  axi_inter_cmd_driver_if ifb ();

  axi_inter_cmd_driver #(.CMD_DEPTH(2), .GAP(0), .TIMEOUT(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  axi_inter_cmd_driver #(.CMD_DEPTH(2), .GAP(2), .TIMEOUT(64)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  wire logic [4:0]  sa = {ifa.in_valid, ifa.action_valid, ifa.formula_valid, ifa.dram_no_valid, ifa.index_valid};
  wire logic [4:0]  sb = {ifb.in_valid, ifb.action_valid, ifb.formula_valid, ifb.dram_no_valid, ifb.index_valid};
  wire logic [32:0] st_a = {sa, ifa.D, ifa.rsp_valid, ifa.rsp_result, ifa.rsp_timeout, ifa.spurious_out, ifa.cmd_ready};
  wire logic [32:0] st_b = {sb, ifb.D, ifb.rsp_valid, ifb.rsp_result, ifb.rsp_timeout, ifb.spurious_out, ifb.cmd_ready};
  localparam logic [32:0] ST_RESET = 33'h1;

  task automatic drive_a(input logic act, input logic [2:0] f, input logic [7:0] dn, input logic [47:0] ix);
    ifa.cmd_action = act; ifa.cmd_formula = f; ifa.cmd_dram_no = dn; ifa.cmd_index = ix;
  endtask

  // Follows a command on port A to its last index strobe, then returns a result on the next cycle.
  task automatic run_cmd(input logic [11:0] res, output logic [7:0] dram_seen, output int nidx);
    nidx = 0; dram_seen = '0;
    for (int k = 0; k < 200 && nidx < 4; k++) begin
      @(negedge clk);
      if (ifa.dram_no_valid) dram_seen = ifa.D[7:0];
      if (ifa.index_valid) nidx++;
    end
    @(negedge clk); ifa.out_valid = 1'b1; ifa.result = res;
    @(negedge clk); ifa.out_valid = 1'b0; ifa.result = 12'hEEE;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ifa.rsp_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (st_a !== ST_RESET) begin n_bad++; $display("FAIL reset_a: got %h want %h", st_a, ST_RESET); end
    n_cmp++;
    if (st_b !== ST_RESET) begin n_bad++; $display("FAIL reset_b: got %h want %h", st_b, ST_RESET); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [4:0]  exp_s [7];
    logic [11:0] exp_d [7];
    logic [4:0]  s_exp;
    logic [11:0] d_exp;
    exp_s = '{5'b11000, 5'b00100, 5'b00010, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    exp_d = '{12'h000, 12'h005, 12'h02A, 12'h001, 12'h002, 12'h003, 12'h004};
    drive_a(1'b0, 3'd5, 8'h2A, {12'h001, 12'h002, 12'h003, 12'h004});
    ifa.cmd_valid = 1'b1;
    @(negedge clk); ifa.cmd_valid = 1'b0;
    for (int j = 0; j < 19; j++) begin
      if (j > 0) @(negedge clk);
      if (j >= 2 && j <= 8) begin s_exp = exp_s[j-2]; d_exp = exp_d[j-2]; end
      else begin s_exp = '0; d_exp = '0; end
      n_cmp++;
      if (sa !== s_exp || ifa.D !== d_exp || ifa.rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL read_field j=%0d: strobes %b D %h rsp %b, want %b %h 0", j, sa, ifa.D, ifa.rsp_valid, s_exp, d_exp);
      end
      if (j == 18) begin ifa.out_valid = 1'b1; ifa.result = 12'h123; end
    end
    @(negedge clk); ifa.out_valid = 1'b0; ifa.result = 12'hEEE;
    n_cmp++;
    if ({ifa.rsp_valid, ifa.rsp_result, ifa.rsp_timeout} !== {1'b1, 12'h123, 1'b0}) begin
      n_bad++;
      $display("FAIL read_rsp: valid %b result %h timeout %b, want 1 123 0", ifa.rsp_valid, ifa.rsp_result, ifa.rsp_timeout);
    end
    @(negedge clk);
    n_cmp++;
    if ({ifa.rsp_valid, ifa.rsp_result} !== {1'b1, 12'h123}) begin
      n_bad++; $display("FAIL read_hold: valid %b result %h, want 1 123", ifa.rsp_valid, ifa.rsp_result);
    end
    ifa.rsp_ready = 1'b1;
    @(negedge clk); ifa.rsp_ready = 1'b0;
    n_cmp++;
    if (ifa.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL read_accept: rsp_valid %b want 0", ifa.rsp_valid); end
  endtask

  task automatic test_gap();
    logic [4:0]  exp_s [7];
    logic [11:0] exp_d [7];
    logic [4:0]  s_exp;
    logic [11:0] d_exp;
    int f;
    exp_s = '{5'b11000, 5'b00100, 5'b00010, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    exp_d = '{12'h001, 12'h003, 12'h05C, 12'hA11, 12'hB22, 12'hC33, 12'hD44};
    ifb.cmd_action = 1'b1; ifb.cmd_formula = 3'd3; ifb.cmd_dram_no = 8'h5C;
    ifb.cmd_index = {12'hA11, 12'hB22, 12'hC33, 12'hD44};
    ifb.cmd_valid = 1'b1;
    @(negedge clk); ifb.cmd_valid = 1'b0;
    for (int j = 0; j < 22; j++) begin
      if (j > 0) @(negedge clk);
      f = j - 2;
      if (f >= 0 && f <= 18 && (f % 3) == 0) begin s_exp = exp_s[f/3]; d_exp = exp_d[f/3]; end
      else begin s_exp = '0; d_exp = '0; end
      n_cmp++;
      if (sb !== s_exp || ifb.D !== d_exp) begin
        n_bad++; $display("FAIL gap_field j=%0d: strobes %b D %h, want %b %h", j, sb, ifb.D, s_exp, d_exp);
      end
      if (j == 21) begin ifb.out_valid = 1'b1; ifb.result = 12'hBEE; end
    end
    @(negedge clk); ifb.out_valid = 1'b0; ifb.result = 12'hEEE;
    n_cmp++;
    if ({ifb.rsp_valid, ifb.rsp_result, ifb.rsp_timeout} !== {1'b1, 12'hBEE, 1'b0}) begin
      n_bad++;
      $display("FAIL gap_rsp: valid %b result %h timeout %b, want 1 bee 0", ifb.rsp_valid, ifb.rsp_result, ifb.rsp_timeout);
    end
    ifb.rsp_ready = 1'b1;
    @(negedge clk); ifb.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    drive_a(1'b0, 3'd1, 8'h10, {12'h111, 12'h222, 12'h333, 12'h444});
    ifa.cmd_valid = 1'b1;
    @(negedge clk); ifa.cmd_valid = 1'b0;
    for (int j = 0; j < 26; j++) begin
      if (j > 0) @(negedge clk);
      n_cmp++;
      if (ifa.rsp_valid !== (j >= 25)) begin
        n_bad++; $display("FAIL timeout_edge j=%0d: rsp_valid %b want %b", j, ifa.rsp_valid, (j >= 25));
      end
    end
    n_cmp++;
    if ({ifa.rsp_result, ifa.rsp_timeout} !== {12'h000, 1'b1}) begin
      n_bad++; $display("FAIL timeout_rsp: result %h timeout %b, want 000 1", ifa.rsp_result, ifa.rsp_timeout);
    end
    ifa.rsp_ready = 1'b1;
    @(negedge clk); ifa.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  dseen;
    logic [11:0] res;
    int          nidx, hold_bad;
    bit          got;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (ifa.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_push%0d: got %b want 1", c, ifa.cmd_ready); end
      drive_a(1'b0, 3'(c), 8'(c), {4{12'(c)}});
      ifa.cmd_valid = 1'b1;
      @(negedge clk);
    end
    ifa.cmd_valid = 1'b0;
    n_cmp++;
    if (ifa.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: cmd_ready %b want 0", ifa.cmd_ready); end
    for (int c = 1; c <= 3; c++) begin
      res = 12'h111 * 12'(c);
      run_cmd(res, dseen, nidx);
      n_cmp++;
      if (nidx != 4 || dseen !== 8'(c)) begin
        n_bad++; $display("FAIL b2b_order%0d: idx strobes %0d dram %h, want 4 %h", c, nidx, dseen, 8'(c));
      end
      wait_rsp(got);
      n_cmp++;
      if (!got || ifa.rsp_result !== res || ifa.rsp_timeout !== 1'b0) begin
        n_bad++; $display("FAIL b2b_rsp%0d: got %b result %h, want 1 %h", c, got, ifa.rsp_result, res);
      end
      if (c == 1) begin
        hold_bad = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (ifa.in_valid || !ifa.rsp_valid || ifa.rsp_result !== res) hold_bad++;
        end
        n_cmp++;
        if (hold_bad != 0) begin n_bad++; $display("FAIL b2b_hold: %0d bad cycles, want 0", hold_bad); end
      end
      ifa.rsp_ready = 1'b1;
      @(negedge clk); ifa.rsp_ready = 1'b0;
      if (c == 2) begin
        n_cmp++;
        if (ifa.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_back: got %b want 1", ifa.cmd_ready); end
      end
    end
  endtask

  task automatic test_spurious();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifa.spurious_out !== 1'b0) begin n_bad++; $display("FAIL spur_before: got %b want 0", ifa.spurious_out); end
    ifa.out_valid = 1'b1;
    @(negedge clk); ifa.out_valid = 1'b0;
    n_cmp++;
    if (ifa.spurious_out !== 1'b1) begin n_bad++; $display("FAIL spur_set: got %b want 1", ifa.spurious_out); end
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({ifa.spurious_out, ifa.rsp_valid, sa, ifb.spurious_out} !== {1'b1, 1'b0, 5'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL spur_sticky: spur %b rsp %b strobes %b spur_b %b, want 1 0 00000 0", ifa.spurious_out, ifa.rsp_valid, sa, ifb.spurious_out);
    end
  endtask

  task automatic test_reset_mid_idx();
    int quiet_bad;
    drive_a(1'b0, 3'd2, 8'h77, {12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4});
    ifa.cmd_valid = 1'b1;
    @(negedge clk); ifa.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({ifa.index_valid, ifa.D} !== {1'b1, 12'h0B2}) begin
      n_bad++; $display("FAIL rst_pre: index_valid %b D %h, want 1 0b2", ifa.index_valid, ifa.D);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++;
    if (st_a !== ST_RESET) begin n_bad++; $display("FAIL rst_mid: got %h want %h", st_a, ST_RESET); end
    quiet_bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ifa.rsp_valid || sa != 5'b0) quiet_bad++;
    end
    n_cmp++;
    if (quiet_bad != 0) begin n_bad++; $display("FAIL rst_drop: %0d active cycles, want 0", quiet_bad); end
  endtask

  initial begin
    ifa.cmd_valid = 1'b0; ifa.rsp_ready = 1'b0; ifa.out_valid = 1'b0; ifa.result = 12'hEEE;
    ifb.cmd_valid = 1'b0; ifb.rsp_ready = 1'b0; ifb.out_valid = 1'b0; ifb.result = 12'hEEE;
    drive_a(1'b0, 3'd0, 8'd0, 48'd0);
    ifb.cmd_action = 1'b0; ifb.cmd_formula = '0; ifb.cmd_dram_no = '0; ifb.cmd_index = '0;
    test_reset();
    test_read();
    test_gap();
    test_timeout();
    test_back_to_back();
    test_spurious();
    test_reset_mid_idx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
`default_nettype wire
